serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing dif = a - b - brw_in, one bit per clock, LSB first.
- Feeds operand bits and a registered borrow into a single full-subtractor cell.
- Collects the difference bits into a result register and reports final borrow and signed overflow.
- Sits between operand-producing logic and any consumer that needs multi-bit differences at low area cost.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request to begin a subtraction; sampled only in IDLE.
- a_i  input  WIDTH  minuend; captured on the accepted start cycle.
- b_i  input  WIDTH  subtrahend; captured on the accepted start cycle.
- brw_i  input  1  borrow-in for the LSB; captured on the accepted start cycle.
- busy_o  output  1  high in SHIFT and DONE.
- done_o  output  1  single-cycle pulse; result valid.
- dif_o  output  WIDTH  difference result register.
- brw_o  output  1  final borrow-out (high means unsigned a < b + brw_i).
- ovf_o  output  1  signed two's-complement overflow of the subtraction.

Behaviour:
- Interface: one clock clk_i; reset rst_i is asynchronous and active-high.
- Reset: state=IDLE; busy_o=0, done_o=0, dif_o=0, brw_o=0, ovf_o=0; all operand, shift, borrow and count registers cleared.
- FSM states are IDLE, SHIFT and DONE.
- IDLE, start_i=1:
  - load a_sh<=a_i, b_sh<=b_i, brw_q<=brw_i, cnt<=0.
  - latch a_msb<=a_i[WIDTH-1], b_msb<=b_i[WIDTH-1].
  - go to SHIFT.
- IDLE, start_i=0: stay in IDLE; outputs hold.
- SHIFT, every cycle:
  - cell inputs are (a_sh[0], b_sh[0], brw_q), producing d and bo.
  - res_sh <= {d, res_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; brw_q <= bo; cnt <= cnt+1.
- SHIFT, when cnt==WIDTH-1 (the last bit):
  - dif_o <= {d, res_sh[WIDTH-1:1]}; brw_o <= bo.
  - ovf_o <= (a_msb != b_msb) && (d != a_msb).
  - go to DONE.
- DONE: done_o=1 for exactly this one cycle, then return to IDLE.
- Latency: start accepted at edge 0; done_o is high in the cycle after edge WIDTH. For WIDTH=8 that is 9 cycles from start to done.
- dif_o, brw_o and ovf_o update only on the final SHIFT edge and hold until the next operation's final edge. Intermediate bits are never visible on the outputs.
- start_i in SHIFT or DONE is ignored and not queued. The earliest next accept is the first IDLE cycle, so back-to-back throughput is one result per WIDTH+2 cycles.
- a_i, b_i and brw_i may change freely after the accept cycle.
- Reset asserted mid-operation aborts immediately to reset values; no done_o pulse follows.
- cnt width is $clog2(WIDTH); the comparison against WIDTH-1 must not wrap for WIDTH a power of two.
- Arithmetic is modulo 2^WIDTH.
- brw_o follows the unsigned borrow chain including brw_i.
- ovf_o is computed from the sign bits of a, b and the result MSB only. brw_i is folded into the result bit, so this rule holds with brw_i=1 as well.

Decomposition:
- Package serial_sub_pkg:
  - state_t enum {IDLE, SHIFT, DONE}.
  - DEFAULT_WIDTH constant.
  - a count-width helper function.
- Sub-module: instantiate the team's existing full_sub_with_halfsub as the single bit cell (a_i, b_i, brw_i -> dif_o, brw_o). No other arithmetic is inferred in this block.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, brw_i=0, start pulse -> done_o 9 cycles later; dif_o=0x1E, brw_o=0, ovf_o=0; busy_o high for 9 cycles.
- a=0x00, b=0x01, brw_i=0 -> dif_o=0xFF, brw_o=1, ovf_o=0.
- a=0x80, b=0x01, brw_i=0 -> dif_o=0x7F, brw_o=0, ovf_o=1. Then a=0x7F, b=0xFF -> dif_o=0x80, brw_o=1, ovf_o=1.
- a=0x10, b=0x0F, brw_i=1 -> dif_o=0x00, brw_o=0. Then a=0x00, b=0x00, brw_i=1 -> dif_o=0xFF, brw_o=1.
- start_i held high continuously with changing operands -> an op is accepted only in IDLE; done_o pulses every 10 cycles; each result matches the operands on its accept cycle; the previous result is stable until the next final edge.
- rst_i asserted asynchronously (mid-clock) during cycle 4 of SHIFT -> all outputs 0 immediately, no done_o. A new start after release gives a correct result (a=0xFF, b=0x01 -> 0xFE).

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   state_t       : controller states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand width
//   cnt_width()   : bit count needed to index WIDTH serial steps
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The bit counter runs 0..w-1, so $clog2(w) bits suffice.
  // The result is clamped to at least 1 so that a zero-width vector can never be declared.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_sub_with_halfsub.sv
// One-bit full subtractor built from two half subtractors.
//   a_i, b_i : operand bits (a - b)
//   brw_i    : borrow in
//   dif_o    : difference bit
//   brw_o    : borrow out
module full_sub_with_halfsub (
  input  logic a_i,
  input  logic b_i,
  input  logic brw_i,
  output logic dif_o,
  output logic brw_o
);

  logic d1, b1, b2;

  // First stage computes a - b. Second stage subtracts the incoming borrow.
  assign d1    = a_i ^ b_i;
  assign b1    = ~a_i & b_i;
  assign dif_o = d1 ^ brw_i;
  assign b2    = ~d1 & brw_i;
  assign brw_o = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: dif = a - b - brw_in, one bit per clock, LSB first.
//   clk_i, rst_i        : clock, async active-high reset
//   start_i             : begin an operation (accepted only in IDLE)
//   a_i, b_i, brw_i     : operands, captured on the accept cycle
//   busy_o              : high in SHIFT and DONE
//   done_o              : one-cycle pulse when the result registers update
//   dif_o, brw_o, ovf_o : difference, final borrow, signed overflow
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             brw_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] dif_o,
  output logic             brw_o,
  output logic             ovf_o
);

  localparam int CW = cnt_width(WIDTH);
  // WIDTH-1 always fits in CW bits, so this compare never wraps.
  // That holds even when WIDTH is a power of two.
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  // This register holds only the WIDTH-1 earlier result bits.
  // The final bit goes straight from the cell into dif_o.
  logic [WIDTH-2:0] res_sh, res_nxt;
  logic             brw_q, a_msb, b_msb;
  logic [CW-1:0]    cnt;
  logic             d, bo;

  full_sub_with_halfsub u_cell (
    .a_i   (a_sh[0]),
    .b_i   (b_sh[0]),
    .brw_i (brw_q),
    .dif_o (d),
    .brw_o (bo)
  );

  generate
    if (WIDTH > 2) begin : g_res_wide
      assign res_nxt = {d, res_sh[WIDTH-2:1]};
    end else begin : g_res_narrow
      assign res_nxt = d;
    end
  endgenerate

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw_q  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      dif_o  <= '0;
      brw_o  <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_sh  <= a_i;
            b_sh  <= b_i;
            brw_q <= brw_i;
            a_msb <= a_i[WIDTH-1];
            b_msb <= b_i[WIDTH-1];
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res_sh <= res_nxt;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          brw_q  <= bo;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            dif_o <= {d, res_sh};
            brw_o <= bo;
            // Overflow happens only when the operand signs differ.
            // It shows up as a result sign that differs from the sign of a.
            ovf_o <= (a_msb != b_msb) && (d != a_msb);
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
